// File: rtl/mem_bank_port_ctrl.sv
// Requester-side driver for one RWx port of a masked register-file bank; optional post-reset sweep to INIT_VALUE.
// Latency: response visible one cycle after request fire, strictly in request order.
// Backpressure: req_ready drops when the 2-entry response FIFO is full; no bypass.

// Generic synchronous FIFO with registered storage cleared on reset.
// Latency: pushed data visible at the head one cycle after the push edge.
// Backpressure: push_rdy low when full; pop on empty is ignored.
module mem_bank_port_ctrl_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_vld,
  output logic         push_rdy,
  input  logic [W-1:0] push_dat,
  output logic         pop_vld,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign push_rdy = (cnt < CW'(DEPTH));
  assign pop_vld  = (cnt != '0);
  assign pop_dat  = mem[rd_ptr];
  assign do_push  = push_vld & push_rdy;
  assign do_pop   = pop_vld & pop_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// Port controller: sweeps the bank after reset, then turns requests into single port cycles.
// Latency: one cycle from fire to rsp_valid; write responses carry the pre-write entry contents.
// Backpressure: req_ready = RUN & (queued responses < 2); held low during reset and sweep.
module mem_bank_port_ctrl #(
  parameter int                        REG_DEPTH     = 4,
  parameter int                        REG_WIDTH     = 64,
  parameter bit                        INIT_ON_RESET = 1'b1,
  parameter logic [REG_WIDTH-1:0]      INIT_VALUE    = '0,
  parameter int                        AW            = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1,
  parameter int                        BW            = REG_WIDTH / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [AW-1:0]        req_addr,
  input  logic [BW-1:0]        req_be,
  input  logic [REG_WIDTH-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_write,
  output logic [REG_WIDTH-1:0] rsp_rdata,
  output logic                 init_done,
  output logic                 mem_wmode,
  output logic [AW-1:0]        mem_addr,
  output logic [REG_WIDTH-1:0] mem_wmask,
  output logic [REG_WIDTH-1:0] mem_wdata,
  input  logic [REG_WIDTH-1:0] mem_rdata
);
  typedef enum logic {ST_INIT, ST_RUN} state_t;

  typedef struct packed {
    logic                 write;
    logic [REG_WIDTH-1:0] rdata;
  } rsp_ent_t;

  state_t               state;
  state_t               state_nxt;
  logic [AW-1:0]        init_cnt;
  logic [AW-1:0]        init_cnt_nxt;
  logic [REG_WIDTH-1:0] be_mask;
  logic                 fifo_push_rdy;
  logic                 fire;
  rsp_ent_t             push_ent;
  rsp_ent_t             pop_ent;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= (INIT_ON_RESET != 1'b0) ? ST_INIT : ST_RUN;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    case (state)
      ST_INIT: begin
        init_cnt_nxt = init_cnt + 1'b1;
        if (init_cnt == AW'(REG_DEPTH - 1)) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  // Gating with rst keeps the port idle for the whole reset pulse, even mid-sweep.
  assign req_ready = (state == ST_RUN) & ~rst & fifo_push_rdy;
  assign fire      = req_valid & req_ready;

  always_comb begin
    be_mask = '0;
    for (int i = 0; i < BW; i++) begin
      be_mask[8*i +: 8] = {8{req_be[i]}};
    end
  end

  always_comb begin
    mem_wmode = 1'b0;
    mem_addr  = req_addr;
    mem_wmask = '0;
    mem_wdata = req_wdata;
    init_done = 1'b0;
    if (!rst) begin
      case (state)
        ST_INIT: begin
          mem_wmode = 1'b1;
          mem_addr  = init_cnt;
          mem_wmask = '1;
          mem_wdata = INIT_VALUE;
        end
        ST_RUN: begin
          init_done = 1'b1;
          mem_wmode = fire & req_write;
          mem_wmask = fire ? be_mask : '0;
        end
        default: begin
          mem_wmode = 1'b0;
        end
      endcase
    end
  end

  // The bank read is combinational, so the captured data predates any write landing at this edge.
  assign push_ent = '{write: req_write, rdata: mem_rdata};

  mem_bank_port_ctrl_fifo #(
    .W     ($bits(rsp_ent_t)),
    .DEPTH (2)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (fire),
    .push_rdy (fifo_push_rdy),
    .push_dat (push_ent),
    .pop_vld  (rsp_valid),
    .pop_rdy  (rsp_ready),
    .pop_dat  (pop_ent)
  );

  assign rsp_write = pop_ent.write;
  assign rsp_rdata = pop_ent.rdata;
endmodule

// File: tb/tb_mem_bank_port_ctrl.sv
// Directed bench for mem_bank_port_ctrl with a behavioural masked bank on the port.
module tb_mem_bank_port_ctrl;
  localparam int DEPTH = 4;
  localparam int WIDTH = 64;
  localparam int AW    = 2;
  localparam int BW    = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [AW-1:0]    req_addr;
  logic [BW-1:0]    req_be;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_write;
  logic [WIDTH-1:0] rsp_rdata;
  logic             init_done;
  logic             mem_wmode;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wmask;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;

  logic [WIDTH-1:0] bank [DEPTH];
  logic             scramble;
  int               n_cmp = 0;
  int               n_err = 0;

  always #5 clk = ~clk;

  mem_bank_port_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_be    (req_be),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_rdata (rsp_rdata),
    .init_done (init_done),
    .mem_wmode (mem_wmode),
    .mem_addr  (mem_addr),
    .mem_wmask (mem_wmask),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  assign mem_rdata = bank[mem_addr];

  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < DEPTH; i++) bank[i] <= 64'hA5A5_0000_0000_0000 | 64'(i + 1);
    end else if (mem_wmode) begin
      bank[mem_addr] <= (bank[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; scramble = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = '0; req_be = '1; req_wdata = '1; rsp_ready = 1'b1;
    tick(); tick();
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rst_req_ready: got %b exp 0", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b exp 0", rsp_valid); end
    n_cmp++; if (rsp_write !== 1'b0) begin n_err++; $display("FAIL rst_rsp_write: got %b exp 0", rsp_write); end
    n_cmp++; if (rsp_rdata !== 64'h0) begin n_err++; $display("FAIL rst_rsp_rdata: got %h exp 0", rsp_rdata); end
    n_cmp++; if (init_done !== 1'b0) begin n_err++; $display("FAIL rst_init_done: got %b exp 0", init_done); end
    n_cmp++; if (mem_wmode !== 1'b0) begin n_err++; $display("FAIL rst_mem_wmode: got %b exp 0", mem_wmode); end
    req_valid = 1'b0; req_write = 1'b0; req_be = '0; req_wdata = '0; rsp_ready = 1'b0;
    scramble = 1'b0;
  endtask

  task automatic test_init_sweep();
    tick();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      n_cmp++; if (mem_wmode !== 1'b1) begin n_err++; $display("FAIL sweep_wmode[%0d]: got %b exp 1", i, mem_wmode); end
      n_cmp++; if (mem_addr !== AW'(i)) begin n_err++; $display("FAIL sweep_addr[%0d]: got %0d exp %0d", i, mem_addr, i); end
      n_cmp++; if (mem_wmask !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL sweep_wmask[%0d]: got %h", i, mem_wmask); end
      n_cmp++; if (mem_wdata !== 64'h0) begin n_err++; $display("FAIL sweep_wdata[%0d]: got %h exp 0", i, mem_wdata); end
      n_cmp++; if (req_ready !== 1'b0 || init_done !== 1'b0) begin
        n_err++; $display("FAIL sweep_ready_done[%0d]: got %b/%b exp 0/0", i, req_ready, init_done);
      end
      tick();
    end
    #1;
    n_cmp++; if (init_done !== 1'b1) begin n_err++; $display("FAIL sweep_init_done: got %b exp 1", init_done); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL sweep_req_ready: got %b exp 1", req_ready); end
    n_cmp++; if (mem_wmode !== 1'b0) begin n_err++; $display("FAIL sweep_idle_wmode: got %b exp 0", mem_wmode); end
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++; if (bank[i] !== 64'h0) begin n_err++; $display("FAIL sweep_bank[%0d]: got %h exp 0", i, bank[i]); end
    end
  endtask

  task automatic test_write_read();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd2; req_be = 8'h0F;
    req_wdata = 64'h1122_3344_5566_7788; rsp_ready = 1'b1;
    #1;
    n_cmp++; if (mem_wmode !== 1'b1) begin n_err++; $display("FAIL wr_wmode: got %b exp 1", mem_wmode); end
    n_cmp++; if (mem_wmask !== 64'h0000_0000_FFFF_FFFF) begin n_err++; $display("FAIL wr_wmask: got %h exp 00000000ffffffff", mem_wmask); end
    n_cmp++; if (mem_addr !== 2'd2) begin n_err++; $display("FAIL wr_addr: got %0d exp 2", mem_addr); end
    tick();
    req_write = 1'b0;
    #1;
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL wr_rsp_valid: got %b exp 1", rsp_valid); end
    n_cmp++; if (rsp_write !== 1'b1) begin n_err++; $display("FAIL wr_rsp_write: got %b exp 1", rsp_write); end
    n_cmp++; if (rsp_rdata !== 64'h0) begin n_err++; $display("FAIL wr_rsp_rdata: got %h exp 0", rsp_rdata); end
    n_cmp++; if (mem_wmode !== 1'b0) begin n_err++; $display("FAIL rd_wmode: got %b exp 0", mem_wmode); end
    tick();
    req_valid = 1'b0;
    #1;
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL rd_rsp_valid: got %b exp 1", rsp_valid); end
    n_cmp++; if (rsp_write !== 1'b0) begin n_err++; $display("FAIL rd_rsp_write: got %b exp 0", rsp_write); end
    n_cmp++; if (rsp_rdata !== 64'h0000_0000_5566_7788) begin n_err++; $display("FAIL rd_rsp_rdata: got %h exp 0000000055667788", rsp_rdata); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rd_drain: got %b exp 0", rsp_valid); end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_be = 8'hFF;
    req_addr = 2'd0; req_wdata = 64'd1; tick();
    req_addr = 2'd1; req_wdata = 64'd2; tick();
    req_addr = 2'd3; req_wdata = 64'd3; tick();
    req_valid = 1'b0; tick(); tick();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_preload_drain: got %b exp 0", rsp_valid); end
    rsp_ready = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd0;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_cnt0: got %b exp 1", req_ready); end
    tick();
    req_addr = 2'd1;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_cnt1: got %b exp 1", req_ready); end
    tick();
    req_addr = 2'd3;
    #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_full: got %b exp 0", req_ready); end
    tick(); tick();
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_stall: got %b exp 0", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b0 || rsp_rdata !== 64'd1) begin
      n_err++; $display("FAIL bp_hold_head: got v=%b w=%b d=%h exp 1/0/1", rsp_valid, rsp_write, rsp_rdata);
    end
    rsp_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_no_bypass: got %b exp 0", req_ready); end
    tick();
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_after_pop: got %b exp 1", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 64'd2) begin
      n_err++; $display("FAIL bp_rsp2: got v=%b d=%h exp 1/2", rsp_valid, rsp_rdata);
    end
    tick();
    req_valid = 1'b0;
    #1;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 64'd3) begin
      n_err++; $display("FAIL pushpop_rsp3: got v=%b d=%h exp 1/3", rsp_valid, rsp_rdata);
    end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL pushpop_count1: got ready %b exp 1", req_ready); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_final_drain: got %b exp 0", rsp_valid); end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd1;
    tick();
    req_valid = 1'b0;
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL mid_queued: got %b exp 1", rsp_valid); end
    rst = 1'b1;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || init_done !== 1'b0) begin
      n_err++; $display("FAIL mid_rst_outputs: got v=%b r=%b d=%b exp 0/0/0", rsp_valid, req_ready, init_done);
    end
    tick();
    rst = 1'b0;
    tick(); tick();
    n_cmp++; if (mem_addr !== 2'd2 || mem_wmode !== 1'b1) begin
      n_err++; $display("FAIL mid_cnt2: got addr=%0d wmode=%b exp 2/1", mem_addr, mem_wmode);
    end
    rst = 1'b1;
    #1;
    n_cmp++; if (mem_wmode !== 1'b0 || mem_wmask !== 64'h0) begin
      n_err++; $display("FAIL mid_rst_port: got wmode=%b wmask=%h exp 0/0", mem_wmode, mem_wmask);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      n_cmp++; if (mem_addr !== AW'(i) || mem_wmode !== 1'b1 || init_done !== 1'b0) begin
        n_err++; $display("FAIL mid_sweep[%0d]: got addr=%0d wmode=%b done=%b exp %0d/1/0", i, mem_addr, mem_wmode, init_done, i);
      end
      tick();
    end
    #1;
    n_cmp++; if (init_done !== 1'b1 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL mid_done: got done=%b ready=%b v=%b exp 1/1/0", init_done, req_ready, rsp_valid);
    end
    n_cmp++; if (bank[3] !== 64'h0) begin n_err++; $display("FAIL mid_bank3: got %h exp 0", bank[3]); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_init_sweep();
    test_write_read();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
